// File: rtl/shift_arbiter.sv
// Two-port request arbiter that serialises shift operations onto one shared
// external shifter. Optional macro SHIFT_ARB_ROL_EN enables op 100 as rotate-left.
module shift_arbiter #(
  parameter bit PRIO_FIXED = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [2:0]  req0_op,
  input  logic [31:0] req0_data,
  input  logic [4:0]  req0_amt,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [2:0]  req1_op,
  input  logic [31:0] req1_data,
  input  logic [4:0]  req1_amt,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic [31:0] sh_data,
  output logic [1:0]  sh_op,
  output logic [4:0]  sh_amt,
  input  logic [31:0] sh_result,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      r_state;
  logic        r_port;
  logic        r_last;
  logic [2:0]  r_op;
  logic [31:0] r_data;
  logic [4:0]  r_amt;
  logic [31:0] r_rsp_data;
  logic        r_rsp_err;

  logic        w_live;
  logic        w_rsp_ready;
  logic        w_can;
  logic        w_win;
  logic        w_acc;
  logic [7:0]  w_dec;
  logic        w_legal;
  logic        w_exec;

  // Packs {legal, sh_op, sh_amt}; left shifts are done on the shared shifter
  // as a right shift by the complemented amount.
  function automatic logic [7:0] sh_decode(input logic [2:0] op, input logic [4:0] amt);
    logic [7:0] d;
    d = '0;
    case (op)
      3'b000:  d = {1'b1, 2'b00, ~amt};
      3'b001:  d = {1'b1, 2'b01, amt};
      3'b010:  d = {1'b1, 2'b10, amt};
      3'b011:  d = {1'b1, 2'b11, amt};
`ifdef SHIFT_ARB_ROL_EN
      3'b100:  d = {1'b1, 2'b11, 5'(6'd32 - {1'b0, amt})};
`endif
      default: d = '0;
    endcase
    return d;
  endfunction

  assign w_live      = ~reset;
  assign w_rsp_ready = r_port ? rsp1_ready : rsp0_ready;
  assign w_can       = w_live && ((r_state == IDLE) || ((r_state == RESP) && w_rsp_ready));

  always_comb begin
    if (req0_valid && req1_valid) w_win = PRIO_FIXED ? 1'b0 : ~r_last;
    else                          w_win = ~req0_valid;
  end

  assign w_acc      = w_can & (req0_valid | req1_valid);
  assign req0_ready = w_acc & ~w_win;
  assign req1_ready = w_acc & w_win;

  assign w_dec   = sh_decode(r_op, r_amt);
  assign w_legal = w_dec[7];
  assign w_exec  = w_live && (r_state == EXEC);

  assign sh_data    = w_exec ? r_data : '0;
  assign sh_op      = w_exec ? w_dec[6:5] : '0;
  assign sh_amt     = w_exec ? w_dec[4:0] : '0;
  assign busy       = w_live && (r_state != IDLE);
  assign rsp0_valid = w_live && (r_state == RESP) && ~r_port;
  assign rsp1_valid = w_live && (r_state == RESP) && r_port;
  assign rsp_data   = w_live ? r_rsp_data : '0;
  assign rsp_err    = w_live & r_rsp_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_port     <= 1'b0;
      r_last     <= 1'b1;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
    end else begin
      if (w_acc) begin
        r_port <= w_win;
        r_last <= w_win;
      end
      case (r_state)
        IDLE: if (w_acc) r_state <= EXEC;
        EXEC: begin
          r_state    <= RESP;
          r_rsp_data <= w_legal ? sh_result : '0;
          r_rsp_err  <= ~w_legal;
        end
        RESP: if (w_rsp_ready) r_state <= w_acc ? EXEC : IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Request payload is only meaningful once accepted; no reset needed.
  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_op   <= w_win ? req1_op   : req0_op;
      r_data <= w_win ? req1_data : req0_data;
      r_amt  <= w_win ? req1_amt  : req0_amt;
    end
  end

endmodule

// File: tb/tb_shift_arbiter.sv
// Bench for shift_arbiter: directed scenarios plus random traffic checked
// against a transaction-level reference model with a stub shared shifter.
module tb_shift_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        v0 = 1'b0, v1 = 1'b0;
  logic [2:0]  op0 = '0, op1 = '0;
  logic [31:0] d0 = '0, d1 = '0;
  logic [4:0]  a0 = '0, a1 = '0;
  logic        r0 = 1'b0, r1 = 1'b0;
  logic        f_rdy = 1'b1;

  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_err, busy;
  logic [31:0] rsp_data, sh_data, sh_result;
  logic [1:0]  sh_op;
  logic [4:0]  sh_amt;

  logic        f_req0_ready, f_req1_ready, f_rsp0_valid, f_rsp1_valid, f_rsp_err, f_busy;
  logic [31:0] f_rsp_data, f_sh_data, f_sh_result;
  logic [1:0]  f_sh_op;
  logic [4:0]  f_sh_amt;

  int total = 0;
  int bad = 0;

  bit          m_have = 0;
  int          m_age = 0;
  bit          m_port = 0;
  bit          m_last = 1;
  logic [2:0]  m_op = '0;
  logic [31:0] m_data = '0;
  logic [4:0]  m_amt = '0;
  int          acc_port_q[$];
  int          f_acc0 = 0;

  always #5 clk = ~clk;

  shift_arbiter #(.PRIO_FIXED(1'b0)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(v0), .req0_ready(req0_ready), .req0_op(op0), .req0_data(d0), .req0_amt(a0),
    .req1_valid(v1), .req1_ready(req1_ready), .req1_op(op1), .req1_data(d1), .req1_amt(a1),
    .rsp0_valid(rsp0_valid), .rsp0_ready(r0), .rsp1_valid(rsp1_valid), .rsp1_ready(r1),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .sh_data(sh_data), .sh_op(sh_op), .sh_amt(sh_amt), .sh_result(sh_result), .busy(busy)
  );

  shift_arbiter #(.PRIO_FIXED(1'b1)) dut_f (
    .clk(clk), .reset(reset),
    .req0_valid(v0), .req0_ready(f_req0_ready), .req0_op(op0), .req0_data(d0), .req0_amt(a0),
    .req1_valid(v1), .req1_ready(f_req1_ready), .req1_op(op1), .req1_data(d1), .req1_amt(a1),
    .rsp0_valid(f_rsp0_valid), .rsp0_ready(f_rdy), .rsp1_valid(f_rsp1_valid), .rsp1_ready(f_rdy),
    .rsp_data(f_rsp_data), .rsp_err(f_rsp_err),
    .sh_data(f_sh_data), .sh_op(f_sh_op), .sh_amt(f_sh_amt), .sh_result(f_sh_result), .busy(f_busy)
  );

  // Shared shifter: right-shift datapath; SLL arrives as ~amt and shifts {d,0} right by amt+1.
  function automatic logic [31:0] shf(input logic [31:0] d, input logic [1:0] op, input logic [4:0] a);
    logic [63:0] w;
    case (op)
      2'd0: begin w = {d, 32'h0} >> 1; w = w >> a; return w[31:0]; end
      2'd1: return 32'($signed(d) >>> a);
      2'd2: return d >> a;
      default: begin w = {d, d} >> a; return w[31:0]; end
    endcase
  endfunction

  always_comb sh_result   = shf(sh_data, sh_op, sh_amt);
  always_comb f_sh_result = shf(f_sh_data, f_sh_op, f_sh_amt);

  function automatic void ref_calc(input logic [2:0] op, input logic [31:0] d, input logic [4:0] a,
                                   output logic [31:0] r, output logic e);
    int n;
    n = int'(a);
    e = 1'b0;
    case (op)
      3'd0: r = d << n;
      3'd1: r = 32'($signed(d) >>> n);
      3'd2: r = d >> n;
      3'd3: r = (n == 0) ? d : ((d >> n) | (d << (32 - n)));
`ifdef SHIFT_ARB_ROL_EN
      3'd4: r = (n == 0) ? d : ((d << n) | (d >> (32 - n)));
`endif
      default: begin r = '0; e = 1'b1; end
    endcase
  endfunction

  function automatic logic spec_sh(input logic [2:0] op, input logic [4:0] a,
                                   output logic [1:0] so, output logic [4:0] sa);
    int n;
    n = int'(a);
    so = 2'd0;
    sa = 5'd0;
    case (op)
      3'd0: begin so = 2'd0; sa = 5'(31 - n); end
      3'd1: begin so = 2'd1; sa = a; end
      3'd2: begin so = 2'd2; sa = a; end
      3'd3: begin so = 2'd3; sa = a; end
`ifdef SHIFT_ARB_ROL_EN
      3'd4: begin so = 2'd3; sa = 5'((32 - n) % 32); end
`endif
      default: return 1'b0;
    endcase
    return 1'b1;
  endfunction

  task automatic chk32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    chk32(tag, {31'h0, got}, {31'h0, exp});
  endtask

  task automatic chk_all_zero(input string pfx);
    chk1({pfx, "_req0_ready"}, req0_ready, 1'b0);
    chk1({pfx, "_req1_ready"}, req1_ready, 1'b0);
    chk1({pfx, "_busy"}, busy, 1'b0);
    chk1({pfx, "_rsp0_valid"}, rsp0_valid, 1'b0);
    chk1({pfx, "_rsp1_valid"}, rsp1_valid, 1'b0);
    chk32({pfx, "_rsp_data"}, rsp_data, 32'h0);
    chk1({pfx, "_rsp_err"}, rsp_err, 1'b0);
    chk32({pfx, "_sh_data"}, sh_data, 32'h0);
    chk32({pfx, "_sh_op"}, 32'(sh_op), 32'h0);
    chk32({pfx, "_sh_amt"}, 32'(sh_amt), 32'h0);
  endtask

  // One clock of traffic: predict, check before the edge, then advance the model.
  task automatic tick();
    bit resp_ph, rdy_g, can, win, acc, legal;
    logic [31:0] er;
    logic        ee;
    logic [1:0]  eop;
    logic [4:0]  eamt;
    resp_ph = m_have && (m_age >= 2);
    rdy_g   = m_port ? r1 : r0;
    can     = !m_have || (resp_ph && rdy_g);
    win     = (v0 && v1) ? !m_last : !v0;
    acc     = can && (v0 || v1);
    #1;
    chk1("req0_ready", req0_ready, acc && !win);
    chk1("req1_ready", req1_ready, acc && win);
    chk1("busy", busy, m_have);
    chk1("rsp0_valid", rsp0_valid, resp_ph && !m_port);
    chk1("rsp1_valid", rsp1_valid, resp_ph && m_port);
    if (resp_ph) begin
      ref_calc(m_op, m_data, m_amt, er, ee);
      chk32("rsp_data", rsp_data, er);
      chk1("rsp_err", rsp_err, ee);
    end
    if (m_have && m_age == 1) begin
      chk32("sh_data", sh_data, m_data);
      legal = spec_sh(m_op, m_amt, eop, eamt);
      if (legal) begin
        chk32("sh_op", 32'(sh_op), 32'(eop));
        chk32("sh_amt", 32'(sh_amt), 32'(eamt));
      end
    end else begin
      chk32("sh_data_idle", sh_data, 32'h0);
      chk32("sh_op_idle", 32'(sh_op), 32'h0);
      chk32("sh_amt_idle", 32'(sh_amt), 32'h0);
    end
    chk1("fixed_prio_p1", f_req1_ready & v0, 1'b0);
    if (req0_ready) acc_port_q.push_back(0);
    else if (req1_ready) acc_port_q.push_back(1);
    if (f_req0_ready) f_acc0++;
    @(posedge clk);
    if (resp_ph && rdy_g) m_have = 0;
    else if (m_have && m_age < 2) m_age++;
    if (acc) begin
      m_have = 1;
      m_age  = 1;
      m_port = win;
      m_last = win;
      m_op   = win ? op1 : op0;
      m_data = win ? d1 : d0;
      m_amt  = win ? a1 : a0;
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    v0 = 1'b1;
    v1 = 1'b1;
    #1;
    chk_all_zero("rst_during");
    @(posedge clk);
    #1;
    reset = 1'b0;
    v0 = 1'b0;
    v1 = 1'b0;
    #1;
    chk_all_zero("rst_after");
    m_have = 0;
    m_age  = 0;
    m_port = 0;
    m_last = 1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    do_reset();

    // Port 0 SLL 0xF by 4.
    v0 = 1; op0 = 3'd0; d0 = 32'h0000000F; a0 = 5'd4; r0 = 1; r1 = 1;
    tick();
    v0 = 0;
    #1;
    chk32("sll_sh_op", 32'(sh_op), 32'd0);
    chk32("sll_sh_amt", 32'(sh_amt), 32'd27);
    tick();
    chk1("sll_rsp0_valid", rsp0_valid, 1'b1);
    chk32("sll_rsp_data", rsp_data, 32'h000000F0);
    chk1("sll_rsp_err", rsp_err, 1'b0);
    tick();

    // Port 1 SRA of the sign bit by 31.
    v1 = 1; op1 = 3'd1; d1 = 32'h80000000; a1 = 5'd31;
    tick();
    v1 = 0;
    #1;
    chk32("sra_sh_amt", 32'(sh_amt), 32'd31);
    tick();
    chk1("sra_rsp1_valid", rsp1_valid, 1'b1);
    chk1("sra_rsp0_valid", rsp0_valid, 1'b0);
    chk32("sra_rsp_data", rsp_data, 32'hFFFFFFFF);
    tick();

    // Op 100.
    v0 = 1; op0 = 3'd4; d0 = 32'h12345678; a0 = 5'd8;
    tick();
    v0 = 0;
    #1;
`ifdef SHIFT_ARB_ROL_EN
    chk32("rol_sh_op", 32'(sh_op), 32'd3);
    chk32("rol_sh_amt", 32'(sh_amt), 32'd24);
`endif
    tick();
`ifdef SHIFT_ARB_ROL_EN
    chk32("rol_rsp_data", rsp_data, 32'h34567812);
    chk1("rol_rsp_err", rsp_err, 1'b0);
`else
    chk32("op4_rsp_data", rsp_data, 32'h0);
    chk1("op4_rsp_err", rsp_err, 1'b1);
`endif
    tick();

    // Both ports requesting continuously.
    do_reset();
    v0 = 1; v1 = 1; op0 = 3'd2; op1 = 3'd3; r0 = 1; r1 = 1;
    acc_port_q.delete();
    f_acc0 = 0;
    repeat (8) tick();
    chk32("alt_count", 32'(acc_port_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < acc_port_q.size(); i++)
      chk32("alt_grant", 32'(acc_port_q[i]), 32'(i % 2));
    chk32("fixed_p0_accepts", 32'(f_acc0), 32'd4);
    v0 = 0; v1 = 0;
    repeat (3) tick();

    // Response back-pressure with a pending port 1 request.
    v0 = 1; op0 = 3'd3; d0 = 32'hA5A5_0F0F; a0 = 5'd12; r0 = 0;
    tick();
    v0 = 0;
    tick();
    v1 = 1; op1 = 3'd2; d1 = 32'hDEAD_BEEF; a1 = 5'd4;
    repeat (5) tick();
    r0 = 1;
    tick();
    v1 = 0;
    repeat (3) tick();

    // Reset while a transaction is in EXEC.
    v0 = 1; op0 = 3'd2; d0 = 32'hFFFF_0000; a0 = 5'd8;
    tick();
    v0 = 0;
    do_reset();
    r0 = 1; r1 = 1;
    repeat (4) tick();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      v0  = ($urandom_range(0, 9) < 6);
      v1  = ($urandom_range(0, 9) < 6);
      op0 = 3'($urandom_range(0, 7));
      op1 = 3'($urandom_range(0, 7));
      d0  = $urandom;
      d1  = $urandom;
      a0  = 5'($urandom_range(0, 31));
      a1  = 5'($urandom_range(0, 31));
      r0  = ($urandom_range(0, 9) < 7);
      r1  = ($urandom_range(0, 9) < 7);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
